func_response_checker: RTL and testbench
========================================

# func_response_checker

Self-checking exerciser for the small combinational logic functions built in the adders lab. It drives every input vector of an N-input, single-output function in ascending order. After a programmable settle time it samples the function's output and compares it with an expected truth table. It reports a pass/fail verdict, a mismatch count and the first failing vector, so lab boards check themselves without a simulator bench.

## Interface
Parameters:
- NUM_IN, 3, number of function inputs; 2^NUM_IN vectors per run.
- TRUTH, 8'h96, expected output; bit i = expected f for vec == i (default = full-adder sum x^y^z).
- SETTLE, 2, cycles each vector is held before sampling; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE.
- vec  out  NUM_IN  registered stimulus to the function under test; vec[2]=x, vec[1]=y, vec[0]=z for NUM_IN=3.
- f  in  1  function output, combinational from vec.
- busy  out  1  high from the cycle after start is accepted through the final SAMPLE cycle.
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  high when the last run had zero mismatches; held until the next start is accepted.
- err_count  out  NUM_IN+1  number of mismatches in the last run.
- first_fail  out  NUM_IN  lowest vec that mismatched.
- first_fail_valid  out  1  first_fail holds a real value.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1: vec<=0, settle counter<=SETTLE-1, and pass, err_count, first_fail and first_fail_valid are cleared; go to SETTLE.
- SETTLE: if counter==0, go to SAMPLE; otherwise decrement the counter.
- SAMPLE: compare f with TRUTH[vec].
  - On mismatch: err_count++. If first_fail_valid==0, load first_fail<=vec and set first_fail_valid.
  - If vec==2^NUM_IN-1, go to DONE.
  - Otherwise vec<=vec+1, counter<=SETTLE-1, go to SETTLE.
- DONE: done=1 for this cycle; pass<=(err_count==0) using the final count including the last sample; go to IDLE.
- vec does not wrap during a run. It holds the last vector after the run and returns to 0 on the next accepted start.
- start in any state other than IDLE is ignored. If start is still high when IDLE is re-entered, a new run begins.
- err_count cannot overflow: its width is NUM_IN+1, and the maximum count is 2^NUM_IN.

## Timing
- Reset values (asynchronous, effective immediately): state=IDLE, vec=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, first_fail_valid=0.
- Each vector is held for SETTLE+1 cycles: SETTLE cycles in SETTLE plus 1 in SAMPLE. f is sampled at the clock edge that ends SAMPLE.
- Start is accepted at edge 0. done is high in the cycle following edge 2^NUM_IN*(SETTLE+1); for the defaults that is edge 24.
- busy=1 exactly 2^NUM_IN*(SETTLE+1) cycles per run, and is low during DONE.
- pass, err_count and first_fail are valid and stable from the done cycle until the next start is accepted.
- rst_n asserted mid-run aborts the run. There is no done pulse, and all outputs take their reset values.
- All outputs are registered.

## Structure
- Shared package func_check_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - the default TRUTH constants for the lab functions: FA_SUM=8'h96, FA_CARRY=8'hE8.
- Sub-module settle_timer:
  - load/decrement counter with a zero flag;
  - widthed for SETTLE up to 255.
- Comparison, counters and the vector register stay in the top module.

## Test plan
- Correct full-adder sum model (f=x^y^z), defaults, one start pulse -> vec steps 0..7, each held 3 cycles; done at cycle 24; pass=1, err_count=0, first_fail_valid=0.
- f stuck at 0 -> done at 24; pass=0, err_count=4, first_fail=3'b001, first_fail_valid=1.
- f = carry (majority) against TRUTH=8'h96 -> err_count=6 (vectors 1–6), first_fail=3'b001, pass=0. Rerun with TRUTH=8'hE8 -> pass=1.
- start held high for 60 cycles -> start pulses during busy are ignored; done at cycles 24 and 49; results are cleared at the second start acceptance.
- rst_n pulsed low while vec=3 -> all outputs 0 immediately, no done; the next start gives a full 24-cycle run with correct results.
- SETTLE=1, correct model -> each vec held 2 cycles; done at cycle 16; pass=1.

Source files
------------

// File: rtl/func_check_pkg.sv
// Shared types and constants for the lab function response checker.
// Holds the FSM state encoding and the stock lab truth tables.
package func_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [7:0] FA_SUM   = 8'h96;
    localparam logic [7:0] FA_CARRY = 8'hE8;

endpackage

// File: rtl/func_response_checker_settle_timer.sv
// Settle timer: loadable down-counter with a zero flag.
// Sized for settle times up to 255 cycles.
module settle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: load wins over decrement
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/func_response_checker.sv
// Walks every input vector of a small function, samples its output
// after a settle delay and scores it against an expected truth table.
module func_response_checker
    import func_check_pkg::*;
#(
    parameter int                      NUM_IN = 3,
    parameter logic [2**NUM_IN-1:0]    TRUTH  = FA_SUM,
    parameter int                      SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [NUM_IN-1:0] vec,
    input  logic              f,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [NUM_IN:0]   err_count,
    output logic [NUM_IN-1:0] first_fail,
    output logic              first_fail_valid
);

    localparam logic [7:0]        SET_M1 = 8'(SETTLE - 1);
    localparam logic [NUM_IN-1:0] ONE_V  = 1;
    localparam logic [NUM_IN:0]   ONE_E  = 1;

    state_e            state_q, state_d;
    logic [NUM_IN-1:0] vec_q, vec_d;
    logic [NUM_IN:0]   err_q, err_d;
    logic [NUM_IN-1:0] ff_q, ff_d;
    logic              ffv_q, ffv_d;
    logic              pass_q, pass_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic tmr_load;
    logic tmr_dec;
    logic tmr_zero;
    logic mismatch;
    logic last_vec;

    settle_timer #(.W(8)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .dec_i      (tmr_dec),
        .load_val_i (SET_M1),
        .zero_o     (tmr_zero)
    );

    assign mismatch = (f != TRUTH[vec_q]);
    assign last_vec = &vec_q;

    // run sequencing, scoring and result capture
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        err_d    = err_q;
        ff_d     = ff_q;
        ffv_d    = ffv_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_d    = '0;
                    err_d    = '0;
                    ff_d     = '0;
                    ffv_d    = 1'b0;
                    pass_d   = 1'b0;
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d = ST_SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + ONE_E;
                    if (!ffv_q) begin
                        ff_d  = vec_q;
                        ffv_d = 1'b1;
                    end
                end
                if (last_vec) begin
                    // verdict is ready in the same cycle done pulses
                    pass_d  = (err_d == '0);
                    state_d = ST_DONE;
                end else begin
                    vec_d    = vec_q + ONE_V;
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    assign done_d = (state_d == ST_DONE);

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign vec              = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail       = ff_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_func_response_checker.sv
// Bench for func_response_checker: three instances (default, carry
// truth table, SETTLE=1) driven from a vector table with a scoreboard.
module tb_func_response_checker;
    import func_check_pkg::*;

    typedef struct {
        bit pass;
        int err;
        int ff;
        bit ffv;
    } exp_t;

    typedef struct {
        int inst;
        int mode;
        bit pass;
        int err;
        int ff;
        bit ffv;
        int lat;
    } vec_t;

    logic clk;
    logic rst_n;
    logic start_a [3];
    int   mode_a  [3];

    logic [2:0] vec_a  [3];
    logic [2:0] ff_a   [3];
    logic [3:0] err_a  [3];
    logic       busy_a [3];
    logic       done_a [3];
    logic       pass_a [3];
    logic       ffv_a  [3];

    int pass_cnt = 0;
    int total_cnt = 0;
    exp_t sb[$];
    vec_t tbl[$];

    // 0: x^y^z, 1: stuck at 0, 2: majority
    function automatic logic fmodel(input int m, input logic [2:0] v);
        case (m)
            0: return ^v;
            1: return 1'b0;
            default: return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [2:0] vec_w, ff_w;
        logic [3:0] err_w;
        logic busy_w, done_w, pass_w, ffv_w, f_w;
        assign f_w = fmodel(mode_a[g], vec_w);
        func_response_checker #(
            .NUM_IN (3),
            .TRUTH  (g == 1 ? FA_CARRY : FA_SUM),
            .SETTLE (g == 2 ? 1 : 2)
        ) u_dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .start            (start_a[g]),
            .vec              (vec_w),
            .f                (f_w),
            .busy             (busy_w),
            .done             (done_w),
            .pass             (pass_w),
            .err_count        (err_w),
            .first_fail       (ff_w),
            .first_fail_valid (ffv_w)
        );
        assign vec_a[g]  = vec_w;
        assign ff_a[g]   = ff_w;
        assign err_a[g]  = err_w;
        assign busy_a[g] = busy_w;
        assign done_a[g] = done_w;
        assign pass_a[g] = pass_w;
        assign ffv_a[g]  = ffv_w;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sb_compare(input int idx, input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, " sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, " pass"}, int'(pass_a[idx]), int'(e.pass));
        chk({tag, " err_count"}, int'(err_a[idx]), e.err);
        chk({tag, " first_fail"}, int'(ff_a[idx]), e.ff);
        chk({tag, " ff_valid"}, int'(ffv_a[idx]), int'(e.ffv));
    endtask

    task automatic do_run(input int idx, input int hold,
                          output int lat, output int bcnt,
                          output bit hold_ok);
        int cur;
        int run_len;
        @(negedge clk);
        start_a[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a[idx] = 1'b0;
        lat = -1;
        bcnt = 0;
        hold_ok = 1'b1;
        cur = 0;
        run_len = 0;
        for (int n = 0; n < 200; n++) begin
            if (busy_a[idx]) begin
                bcnt++;
                if (int'(vec_a[idx]) == cur) begin
                    run_len++;
                end else begin
                    if (run_len != hold || int'(vec_a[idx]) != cur + 1)
                        hold_ok = 1'b0;
                    cur = int'(vec_a[idx]);
                    run_len = 1;
                end
            end
            if (done_a[idx]) begin
                lat = n;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (run_len != hold || cur != 7) hold_ok = 1'b0;
    endtask

    task automatic table_run(input vec_t t, input string tag);
        int lat, bcnt;
        bit hold_ok;
        int hold;
        exp_t e;
        hold = t.lat / 8;
        mode_a[t.inst] = t.mode;
        e.pass = t.pass;
        e.err = t.err;
        e.ff = t.ff;
        e.ffv = t.ffv;
        sb.push_back(e);
        do_run(t.inst, hold, lat, bcnt, hold_ok);
        chk({tag, " done_latency"}, lat, t.lat);
        chk({tag, " busy_cycles"}, bcnt, t.lat);
        chk({tag, " vec_hold"}, int'(hold_ok), 1);
        sb_compare(t.inst, tag);
        repeat (3) @(negedge clk);
        chk({tag, " pass_held"}, int'(pass_a[t.inst]), int'(t.pass));
        chk({tag, " err_held"}, int'(err_a[t.inst]), t.err);
    endtask

    initial begin
        int ndone;
        int d1;
        int d2;
        bit seen1;
        bit clr_chk;
        bit hit;
        exp_t e;

        tbl.push_back('{0, 0, 1'b1, 0, 0, 1'b0, 24});
        tbl.push_back('{0, 1, 1'b0, 4, 1, 1'b1, 24});
        tbl.push_back('{0, 2, 1'b0, 6, 1, 1'b1, 24});
        tbl.push_back('{1, 2, 1'b1, 0, 0, 1'b0, 24});
        tbl.push_back('{1, 0, 1'b0, 6, 1, 1'b1, 24});
        tbl.push_back('{2, 0, 1'b1, 0, 0, 1'b0, 16});
        tbl.push_back('{2, 1, 1'b0, 4, 1, 1'b1, 16});

        for (int i = 0; i < 3; i++) begin
            start_a[i] = 1'b0;
            mode_a[i] = 0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst vec", int'(vec_a[0]), 0);
        chk("rst busy", int'(busy_a[0]), 0);
        chk("rst done", int'(done_a[0]), 0);
        chk("rst pass", int'(pass_a[0]), 0);
        chk("rst err_count", int'(err_a[0]), 0);
        chk("rst ff_valid", int'(ffv_a[0]), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (tbl[i]) begin
            table_run(tbl[i], $sformatf("tbl%0d", i));
        end

        // abort mid-run with reset while vec==3
        mode_a[0] = 0;
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (vec_a[0] == 3'd3) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("abort reached_vec3", int'(hit), 1);
        rst_n = 1'b0;
        #1;
        chk("abort vec", int'(vec_a[0]), 0);
        chk("abort busy", int'(busy_a[0]), 0);
        chk("abort pass", int'(pass_a[0]), 0);
        chk("abort err_count", int'(err_a[0]), 0);
        chk("abort first_fail", int'(ff_a[0]), 0);
        chk("abort ff_valid", int'(ffv_a[0]), 0);
        ndone = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (done_a[0]) ndone++;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done_a[0]) ndone++;
        end
        chk("abort no_done", ndone, 0);
        table_run(tbl[0], "post_abort");

        // start held high for 60 cycles, stuck-at-0 model
        mode_a[0] = 1;
        e.pass = 1'b0;
        e.err = 4;
        e.ff = 1;
        e.ffv = 1'b1;
        repeat (3) sb.push_back(e);
        @(negedge clk);
        start_a[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ndone = 0;
        d1 = -1;
        d2 = -1;
        seen1 = 1'b0;
        clr_chk = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (n == 60) start_a[0] = 1'b0;
            if (seen1 && !clr_chk && busy_a[0]) begin
                clr_chk = 1'b1;
                chk("held clr err_count", int'(err_a[0]), 0);
                chk("held clr ff_valid", int'(ffv_a[0]), 0);
                chk("held clr pass", int'(pass_a[0]), 0);
            end
            if (done_a[0]) begin
                ndone++;
                if (ndone == 1) begin
                    d1 = n;
                    seen1 = 1'b1;
                end
                if (ndone == 2) d2 = n;
                sb_compare(0, $sformatf("held_run%0d", ndone));
                if (ndone == 3) break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        start_a[0] = 1'b0;
        chk("held done1_cycle", d1, 24);
        chk("held done2_cycle", int'(d2 == 49 || d2 == 50), 1);
        chk("held clr_seen", int'(clr_chk), 1);
        chk("held done_count", ndone, 3);
        chk("held sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
